// File: rtl/divider_pkg.sv
// Shared definitions for the sequential restoring divider: FSM state encoding and
// iteration-counter sizing.
package divider_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StCalc = 2'd1,
    StDone = 2'd2
  } state_e;

  // Counter must hold 0..2*n so the final iteration index is representable.
  function automatic int unsigned cnt_width(input int unsigned n);
    return $clog2(2 * n + 1);
  endfunction

endpackage

// File: rtl/n_bit_adder.sv
// Ripple-style N_BITS-wide adder with carry in/out; shared arithmetic building block.
module n_bit_adder #(
  parameter int unsigned N_BITS = 4
) (
  input  logic [N_BITS-1:0] a,
  input  logic [N_BITS-1:0] b,
  input  logic              c_in,
  output logic [N_BITS-1:0] sum,
  output logic              c_out
);

  logic [N_BITS:0] full;

  assign full  = {1'b0, a} + {1'b0, b} + {{N_BITS{1'b0}}, c_in};
  assign sum   = full[N_BITS-1:0];
  assign c_out = full[N_BITS];

endmodule

// File: rtl/divider.sv
// Sequential restoring divider: 2*N_BITS dividend by N_BITS divisor, one quotient bit
// per cycle, start/done handshake with results held until the next accepted start.
module divider
  import divider_pkg::*;
#(
  parameter int unsigned N_BITS = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_start,
  input  logic [2*N_BITS-1:0]   i_dividend,
  input  logic [N_BITS-1:0]     i_divisor,
  output logic                  o_busy,
  output logic                  o_done,
  output logic [2*N_BITS-1:0]   o_quotient,
  output logic [N_BITS-1:0]     o_remainder,
  output logic                  o_div_by_zero
);

  localparam int unsigned QW = 2 * N_BITS;
  localparam int unsigned CW = cnt_width(N_BITS);
  localparam logic [CW-1:0] LastCnt = CW'(QW - 1);
  localparam logic [CW-1:0] CntOne  = CW'(1);

  state_e            state_q;
  logic [QW-1:0]     quo_q;
  logic [N_BITS:0]   rem_q;
  logic [N_BITS-1:0] dvs_q;
  logic [CW-1:0]     cnt_q;

  logic [N_BITS:0]   rem_sh;
  logic [N_BITS:0]   trial;
  logic              no_borrow;
  logic [N_BITS:0]   rem_nxt;
  logic [QW-1:0]     quo_nxt;

  // rem_q never exceeds the divisor, so dropping its top bit on the shift loses nothing.
  assign rem_sh = (N_BITS + 1)'({rem_q, quo_q[QW-1]});

  // rem_sh + ~divisor + 1 == rem_sh - divisor; carry out set means no borrow.
  n_bit_adder #(
    .N_BITS (N_BITS + 1)
  ) u_trial (
    .a     (rem_sh),
    .b     (~{1'b0, dvs_q}),
    .c_in  (1'b1),
    .sum   (trial),
    .c_out (no_borrow)
  );

  always_comb begin
    rem_nxt = rem_sh;
    quo_nxt = {quo_q[QW-2:0], 1'b0};
    if (no_borrow) begin
      rem_nxt    = trial;
      quo_nxt[0] = 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q       <= StIdle;
      quo_q         <= '0;
      rem_q         <= '0;
      dvs_q         <= '0;
      cnt_q         <= '0;
      o_busy        <= 1'b0;
      o_done        <= 1'b0;
      o_quotient    <= '0;
      o_remainder   <= '0;
      o_div_by_zero <= 1'b0;
    end else begin
      o_done <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (i_start) begin
            o_busy <= 1'b1;
            if (i_divisor != '0) begin
              quo_q         <= i_dividend;
              rem_q         <= '0;
              dvs_q         <= i_divisor;
              cnt_q         <= '0;
              o_div_by_zero <= 1'b0;
              state_q       <= StCalc;
            end else begin
              o_quotient    <= '1;
              o_remainder   <= i_dividend[N_BITS-1:0];
              o_div_by_zero <= 1'b1;
              o_done        <= 1'b1;
              state_q       <= StDone;
            end
          end
        end
        StCalc: begin
          quo_q <= quo_nxt;
          rem_q <= rem_nxt;
          cnt_q <= cnt_q + CntOne;
          if (cnt_q == LastCnt) begin
            o_quotient  <= quo_nxt;
            o_remainder <= rem_nxt[N_BITS-1:0];
            o_done      <= 1'b1;
            state_q     <= StDone;
          end
        end
        StDone: begin
          o_busy  <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_divider.sv
// Self-checking bench for divider (N_BITS=4): directed cases, divide-by-zero, ignored
// starts, mid-run reset, back-to-back, round-trip sweep and random operands.
module tb_divider;

  localparam int N = 4;

  logic           clk;
  logic           rst_n;
  logic           start;
  logic [2*N-1:0] dividend;
  logic [N-1:0]   divisor;
  logic           busy;
  logic           done;
  logic [2*N-1:0] quotient;
  logic [N-1:0]   remainder;
  logic           dbz;

  int checks;
  int passed;
  int done_cnt;

  divider #(
    .N_BITS (N)
  ) dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_start       (start),
    .i_dividend    (dividend),
    .i_divisor     (divisor),
    .o_busy        (busy),
    .o_done        (done),
    .o_quotient    (quotient),
    .o_remainder   (remainder),
    .o_div_by_zero (dbz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (done === 1'b1) done_cnt++;

  // Reference model: plain integer division, all-ones / low bits on a zero divisor.
  function automatic logic [2*N-1:0] ref_q(input int dd, input int dv);
    if (dv == 0) return {(2*N){1'b1}};
    return (2*N)'(dd / dv);
  endfunction

  function automatic logic [N-1:0] ref_r(input int dd, input int dv);
    if (dv == 0) return N'(dd % (1 << N));
    return N'(dd % dv);
  endfunction

  // Issues one start from IDLE; lat = cycles after the accepting edge until o_done, -1 if none.
  task automatic do_div(input int dd, input int dv, output int lat);
    @(negedge clk);
    start    = 1'b1;
    dividend = (2*N)'(dd);
    divisor  = N'(dv);
    @(posedge clk);
    #1;
    start    = 1'b0;
    dividend = (2*N)'($urandom);
    divisor  = N'($urandom);
    lat = -1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic check_result(input string name, input int dd, input int dv, input int lat);
    int exp_lat;
    exp_lat = (dv == 0) ? 0 : 2 * N;
    checks++;
    if (lat !== exp_lat) $display("FAIL %s latency: got %0d want %0d", name, lat, exp_lat);
    else passed++;
    checks++;
    if (quotient !== ref_q(dd, dv))
      $display("FAIL %s quotient %0d/%0d: got %0d want %0d", name, dd, dv, quotient, ref_q(dd, dv));
    else passed++;
    checks++;
    if (remainder !== ref_r(dd, dv))
      $display("FAIL %s remainder %0d/%0d: got %0d want %0d", name, dd, dv, remainder,
               ref_r(dd, dv));
    else passed++;
    checks++;
    if (dbz !== (dv == 0))
      $display("FAIL %s div_by_zero %0d/%0d: got %b want %b", name, dd, dv, dbz, dv == 0);
    else passed++;
    checks++;
    if (busy !== 1'b1) $display("FAIL %s busy in done cycle: got %b want 1", name, busy);
    else passed++;
  endtask

  task automatic check_zero_outputs(input string name);
    checks++;
    if ({busy, done, quotient, remainder, dbz} !== '0)
      $display("FAIL %s outputs: got busy=%b done=%b q=%0d r=%0d dbz=%b want all 0",
               name, busy, done, quotient, remainder, dbz);
    else passed++;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b0;
    dividend = '0;
    divisor = '0;
    #12;
    check_zero_outputs("reset_asserted");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_zero_outputs("reset_released");
  endtask

  task automatic test_directed();
    int dds[4] = '{100, 225, 255, 3};
    int dvs[4] = '{7, 15, 1, 9};
    int lat;
    for (int i = 0; i < 4; i++) begin
      do_div(dds[i], dvs[i], lat);
      check_result("directed", dds[i], dvs[i], lat);
    end
  endtask

  task automatic test_div_by_zero();
    int lat;
    do_div(37, 0, lat);
    check_result("dbz", 37, 0, lat);
    do_div(8, 2, lat);
    check_result("dbz_clear", 8, 2, lat);
  endtask

  task automatic test_ignore_start();
    int lat;
    int d0;
    do_div(200, 9, lat);
    check_result("ignore_pre", 200, 9, lat);
    @(negedge clk);
    start    = 1'b1;
    dividend = 8'd100;
    divisor  = 4'd7;
    @(posedge clk);
    d0 = done_cnt;
    for (int e = 1; e <= 12; e++) begin
      #1;
      start    = (e == 3 || e == 8);
      dividend = (2*N)'($urandom);
      divisor  = N'($urandom_range(1, 15));
      if (e == 5) begin
        checks++;
        if (quotient !== ref_q(200, 9))
          $display("FAIL ignore_hold quotient during calc: got %0d want %0d", quotient,
                   ref_q(200, 9));
        else passed++;
      end
      @(posedge clk);
    end
    #1;
    start = 1'b0;
    checks++;
    if (done_cnt - d0 !== 1) $display("FAIL ignore_done_count: got %0d want 1", done_cnt - d0);
    else passed++;
    checks++;
    if (quotient !== 8'd14 || remainder !== 4'd2)
      $display("FAIL ignore_result: got q=%0d r=%0d want q=14 r=2", quotient, remainder);
    else passed++;
  endtask

  task automatic test_reset_mid();
    int lat;
    int d0;
    @(negedge clk);
    start    = 1'b1;
    dividend = 8'd123;
    divisor  = 4'd5;
    @(posedge clk);
    #1;
    start = 1'b0;
    d0 = done_cnt;
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check_zero_outputs("reset_mid");
    repeat (12) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (done_cnt !== d0) $display("FAIL reset_mid_no_done: got %0d pulses want 0", done_cnt - d0);
    else passed++;
    do_div(123, 5, lat);
    check_result("after_reset", 123, 5, lat);
  endtask

  task automatic test_back_to_back();
    int first_k;
    int second_k;
    logic [2*N-1:0] q1;
    logic [N-1:0]   r1;
    first_k  = -1;
    second_k = -1;
    @(negedge clk);
    start    = 1'b1;
    dividend = 8'd100;
    divisor  = 4'd7;
    @(posedge clk);
    #1;
    dividend = 8'd225;
    divisor  = 4'd15;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (k == 2 * N + 2) start = 1'b0;
      if (k == 2 * N + 1) begin
        checks++;
        if (busy !== 1'b0) $display("FAIL b2b_idle_busy: got %b want 0", busy);
        else passed++;
      end
      if (done === 1'b1) begin
        if (first_k < 0) begin
          first_k = k;
          q1 = quotient;
          r1 = remainder;
        end else if (second_k < 0) begin
          second_k = k;
        end
      end
    end
    start = 1'b0;
    checks++;
    if (first_k !== 2 * N || second_k !== 4 * N + 2)
      $display("FAIL b2b_timing: got done at %0d,%0d want %0d,%0d", first_k, second_k, 2 * N,
               4 * N + 2);
    else passed++;
    checks++;
    if (q1 !== 8'd14 || r1 !== 4'd2 || quotient !== 8'd15 || remainder !== 4'd0)
      $display("FAIL b2b_results: got %0d r%0d, %0d r%0d want 14 r2, 15 r0", q1, r1, quotient,
               remainder);
    else passed++;
  endtask

  task automatic test_roundtrip();
    int lat;
    for (int a = 0; a < 16; a++) begin
      for (int b = 1; b < 16; b++) begin
        do_div(a * b, b, lat);
        checks++;
        if (lat !== 2 * N || quotient !== (2*N)'(a) || remainder !== '0)
          $display("FAIL roundtrip %0d*%0d: got q=%0d r=%0d lat=%0d want q=%0d r=0 lat=%0d",
                   a, b, quotient, remainder, lat, a, 2 * N);
        else passed++;
      end
    end
  endtask

  task automatic test_random();
    int lat;
    int dd;
    int dv;
    for (int i = 0; i < 150; i++) begin
      dd = int'($urandom_range(0, 255));
      dv = int'($urandom_range(0, 15));
      do_div(dd, dv, lat);
      check_result("random", dd, dv, lat);
    end
  endtask

  initial begin
    checks   = 0;
    passed   = 0;
    done_cnt = 0;
    test_reset();
    test_directed();
    test_div_by_zero();
    test_ignore_start();
    test_reset_mid();
    test_back_to_back();
    test_roundtrip();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
